universal_poly_hash: RTL and testbench

- Parametrised successor to the fixed 5-term universal hash.
- Computes h(x) = sum c_k * x^k mod P for k = 0..DEGREE, using a Horner pipeline with P = 2^PRIME_EXP - 1 (Mersenne prime).
- Coefficients are runtime-loadable; input and output use valid/ready handshakes with a passthrough ID tag.
- Sits between the key extractor and the SRAM process-table lookup FIFO.

---
 rtl/poly_hash_pkg.sv | 52 +++++
 rtl/poly_hash_horner_stage.sv | 85 ++++++++
 rtl/universal_poly_hash.sv | 180 ++++++++++++++++++
 tb/tb_universal_poly_hash.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_hash_pkg.sv
// rtl/poly_hash_pkg.sv - shared constants and Mersenne arithmetic helpers for universal_poly_hash
//
// Purpose: default coefficients, the maximum supported degree, the modulus
// helper P = 2^e - 1 and the Mersenne reduction used by the input register
// and by every Horner stage.
// Ports: none (package).
package poly_hash_pkg;

  localparam int MAX_DEGREE = 8;

  localparam logic [63:0] C0 = 64'd258021;
  localparam logic [63:0] C1 = 64'd298778;
  localparam logic [63:0] C2 = 64'd56536;
  localparam logic [63:0] C3 = 64'd214992;
  localparam logic [63:0] C4 = 64'd312347;

  // Two folds are enough for any value below 2^(2e), which covers the full
  // h*x product and keys no wider than 2*PRIME_EXP bits.
  localparam int FOLD_PASSES = 2;

  function automatic logic [63:0] prime_of(input int unsigned e);
    return (64'd1 << e) - 64'd1;
  endfunction

  function automatic logic [63:0] default_coeff(input int unsigned k);
    case (k)
      0: return C0;
      1: return C1;
      2: return C2;
      3: return C3;
      4: return C4;
      default: return 64'd0;
    endcase
  endfunction

  // 2^e == 1 (mod P), so the bits above e are folded back onto the low bits.
  // After the folds the value is at most P, which a single subtract fixes.
  function automatic logic [63:0] mersenne_reduce(input logic [127:0] v, input int unsigned e);
    logic [127:0] mask;
    logic [127:0] acc;
    mask = (128'd1 << e) - 128'd1;
    acc  = v;
    for (int i = 0; i < FOLD_PASSES; i++) begin
      acc = (acc & mask) + (acc >> e);
    end
    if (acc >= mask) begin
      acc = acc - mask;
    end
    return acc[63:0];
  endfunction

endpackage

// File: rtl/poly_hash_horner_stage.sv
// rtl/poly_hash_horner_stage.sv - one 2-cycle Horner step: h' = (h*x + coeff) mod P
//
// Purpose: cycle (a) registers the full 2*PRIME_EXP-bit product h*x; cycle (b)
// Mersenne-reduces it, adds coeff and registers the result with one
// conditional subtract. Valid, x and id travel alongside the data.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   en                     global advance; everything holds when low
//   valid, x, h, id        incoming slot (x, h < P)
//   coeff                  coefficient added in cycle (b), < P
//   next_valid, next_x,
//   next_h, next_id        outgoing slot, two enabled cycles later
module poly_hash_horner_stage
  import poly_hash_pkg::*;
#(
  parameter int PRIME_EXP = 31,
  parameter int ID_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 valid,
  input  logic [PRIME_EXP-1:0] x,
  input  logic [PRIME_EXP-1:0] h,
  input  logic [PRIME_EXP-1:0] coeff,
  input  logic [ID_W-1:0]      id,
  output logic                 next_valid,
  output logic [PRIME_EXP-1:0] next_x,
  output logic [PRIME_EXP-1:0] next_h,
  output logic [ID_W-1:0]      next_id
);

  localparam int PROD_W = 2 * PRIME_EXP;
  localparam logic [63:0] P64 = prime_of(PRIME_EXP);
  localparam logic [PRIME_EXP:0] P_EXT = P64[PRIME_EXP:0];

  logic                 prod_valid;
  logic [PROD_W-1:0]    prod;
  logic [PRIME_EXP-1:0] prod_x;
  logic [ID_W-1:0]      prod_id;

  logic [63:0]          red_full;
  logic [PRIME_EXP:0]   sum;
  logic [PRIME_EXP:0]   wrapped;
  logic [PRIME_EXP-1:0] sum_mod;
  logic                 unused_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_valid <= 1'b0;
      prod       <= '0;
      prod_x     <= '0;
      prod_id    <= '0;
    end else if (en) begin
      prod_valid <= valid;
      prod       <= PROD_W'(h) * PROD_W'(x);
      prod_x     <= x;
      prod_id    <= id;
    end
  end

  always_comb begin
    red_full = mersenne_reduce(128'(prod), PRIME_EXP);
    sum      = {1'b0, red_full[PRIME_EXP-1:0]} + {1'b0, coeff};
    wrapped  = sum - P_EXT;
    sum_mod  = (sum >= P_EXT) ? wrapped[PRIME_EXP-1:0] : sum[PRIME_EXP-1:0];
  end

  assign unused_bits = ^{wrapped[PRIME_EXP], red_full[63:PRIME_EXP]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_valid <= 1'b0;
      next_x     <= '0;
      next_h     <= '0;
      next_id    <= '0;
    end else if (en) begin
      next_valid <= prod_valid;
      next_x     <= prod_x;
      next_h     <= sum_mod;
      next_id    <= prod_id;
    end
  end

endmodule

// File: rtl/universal_poly_hash.sv
// rtl/universal_poly_hash.sv - pipelined polynomial hash h(x) = sum c_k*x^k mod (2^PRIME_EXP - 1)
//
// Purpose: input register reduces the key mod P, then DEGREE Horner stages
// (2 cycles each) and an output register; latency 2*DEGREE+1, 1 key/cycle.
// Optional build macro: UNIVERSAL_POLY_HASH_STATS_EN adds stat_hash_cnt and
// stat_stall_cnt (saturating).
// Ports:
//   axi_aclk, axi_aresetn   clock, asynchronous active-low reset
//   s_valid/s_ready/s_key/s_id     key input handshake with sideband tag
//   m_valid/m_ready/m_hash/m_id    hash output handshake with matching tag
//   cfg_we/cfg_addr/cfg_data       coefficient write (only when idle)
//   busy                    a key is somewhere in the pipeline
module universal_poly_hash
  import poly_hash_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PRIME_EXP = 31,
  parameter int DEGREE    = 4,
  parameter int ID_W      = 32
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_key,
  input  logic [ID_W-1:0]      s_id,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [PRIME_EXP-1:0] m_hash,
  output logic [ID_W-1:0]      m_id,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_addr,
  input  logic [PRIME_EXP-1:0] cfg_data,
  output logic                 busy
`ifdef UNIVERSAL_POLY_HASH_STATS_EN
  ,
  output logic [31:0]          stat_hash_cnt,
  output logic [31:0]          stat_stall_cnt
`endif
);

  localparam logic [63:0] P64 = prime_of(PRIME_EXP);
  localparam logic [PRIME_EXP-1:0] P = P64[PRIME_EXP-1:0];

  function automatic logic [DEGREE:0][PRIME_EXP-1:0] build_defaults();
    logic [DEGREE:0][PRIME_EXP-1:0] d;
    logic [63:0] c;
    for (int k = 0; k <= DEGREE; k++) begin
      c    = default_coeff(k) % P64;
      d[k] = c[PRIME_EXP-1:0];
    end
    return d;
  endfunction

  localparam logic [DEGREE:0][PRIME_EXP-1:0] DEFAULTS = build_defaults();

  logic                           en;
  logic [DEGREE:0][PRIME_EXP-1:0] coeff;
  logic                           cfg_apply;
  logic [PRIME_EXP-1:0]           cfg_value;

  logic                           in_valid;
  logic [PRIME_EXP-1:0]           in_x;
  logic [ID_W-1:0]                in_id;
  logic [63:0]                    key_red;

  logic [DEGREE-1:0]              chain_valid;
  logic [PRIME_EXP-1:0]           chain_x  [DEGREE];
  logic [PRIME_EXP-1:0]           chain_h  [DEGREE];
  logic [ID_W-1:0]                chain_id [DEGREE];
  logic                           unused_x;

  // A single global enable: when the output is blocked every register holds,
  // bubbles included, so valid bits never drift relative to their data.
  assign en      = !m_valid || m_ready;
  assign s_ready = en;
  assign busy    = in_valid || (|chain_valid) || m_valid;

  // Writes are dropped unless the pipeline is empty and no key is offered, so
  // a key never sees a mix of old and new coefficients.
  assign cfg_apply = cfg_we && !busy && !s_valid && (int'(cfg_addr) <= DEGREE);
  assign cfg_value = (cfg_data >= P) ? cfg_data - P : cfg_data;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      coeff <= DEFAULTS;
    end else begin
      for (int k = 0; k <= DEGREE; k++) begin
        if (cfg_apply && int'(cfg_addr) == k) begin
          coeff[k] <= cfg_value;
        end
      end
    end
  end

  always_comb begin
    key_red = mersenne_reduce(128'(s_key), PRIME_EXP);
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      in_valid <= 1'b0;
      in_x     <= '0;
      in_id    <= '0;
    end else if (en) begin
      in_valid <= s_valid;
      in_x     <= key_red[PRIME_EXP-1:0];
      in_id    <= s_id;
    end
  end

  for (genvar i = 0; i < DEGREE; i++) begin : g_stage
    logic                 stage_valid;
    logic [PRIME_EXP-1:0] stage_x;
    logic [PRIME_EXP-1:0] stage_h;
    logic [ID_W-1:0]      stage_id;

    if (i == 0) begin : g_first
      // Horner seed: the accumulator entering the first stage is c_DEGREE.
      assign stage_valid = in_valid;
      assign stage_x     = in_x;
      assign stage_h     = coeff[DEGREE];
      assign stage_id    = in_id;
    end else begin : g_next
      assign stage_valid = chain_valid[i-1];
      assign stage_x     = chain_x[i-1];
      assign stage_h     = chain_h[i-1];
      assign stage_id    = chain_id[i-1];
    end

    poly_hash_horner_stage #(
      .PRIME_EXP (PRIME_EXP),
      .ID_W      (ID_W)
    ) u_stage (
      .clk        (axi_aclk),
      .rst_n      (axi_aresetn),
      .en         (en),
      .valid      (stage_valid),
      .x          (stage_x),
      .h          (stage_h),
      .coeff      (coeff[DEGREE-1-i]),
      .id         (stage_id),
      .next_valid (chain_valid[i]),
      .next_x     (chain_x[i]),
      .next_h     (chain_h[i]),
      .next_id    (chain_id[i])
    );
  end

  assign unused_x = ^chain_x[DEGREE-1];

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      m_valid <= 1'b0;
      m_hash  <= '0;
      m_id    <= '0;
    end else if (en) begin
      m_valid <= chain_valid[DEGREE-1];
      m_hash  <= chain_h[DEGREE-1];
      m_id    <= chain_id[DEGREE-1];
    end
  end

`ifdef UNIVERSAL_POLY_HASH_STATS_EN
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      stat_hash_cnt  <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (m_valid && m_ready && stat_hash_cnt != 32'hFFFF_FFFF) begin
        stat_hash_cnt <= stat_hash_cnt + 32'd1;
      end
      if (m_valid && !m_ready && stat_stall_cnt != 32'hFFFF_FFFF) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_universal_poly_hash.sv
// tb/tb_universal_poly_hash.sv - randomized self-checking bench for universal_poly_hash
module tb_universal_poly_hash;

  localparam int DATA_W    = 32;
  localparam int PRIME_EXP = 31;
  localparam int DEGREE    = 4;
  localparam int ID_W      = 32;
  localparam longint unsigned P = 64'h7FFF_FFFF;

  logic                 axi_aclk = 1'b0;
  logic                 axi_aresetn = 1'b0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [DATA_W-1:0]    s_key = '0;
  logic [ID_W-1:0]      s_id = '0;
  logic                 m_valid;
  logic                 m_ready = 1'b1;
  logic [PRIME_EXP-1:0] m_hash;
  logic [ID_W-1:0]      m_id;
  logic                 cfg_we = 1'b0;
  logic [2:0]           cfg_addr = '0;
  logic [PRIME_EXP-1:0] cfg_data = '0;
  logic                 busy;
`ifdef UNIVERSAL_POLY_HASH_STATS_EN
  logic [31:0]          stat_hash_cnt;
  logic [31:0]          stat_stall_cnt;
`endif

  universal_poly_hash #(
    .DATA_W(DATA_W), .PRIME_EXP(PRIME_EXP), .DEGREE(DEGREE), .ID_W(ID_W)
  ) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_key       (s_key),
    .s_id        (s_id),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_hash      (m_hash),
    .m_id        (m_id),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .busy        (busy)
`ifdef UNIVERSAL_POLY_HASH_STATS_EN
    ,
    .stat_hash_cnt  (stat_hash_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct {
    logic [ID_W-1:0] id;
    longint unsigned hash;
    longint          edge_n;
  } exp_t;

  int              tests = 0;
  int              fails = 0;
  longint          cyc = 0;
  longint unsigned mc [DEGREE+1];
  exp_t            exp_q[$];
  bit              rand_ready = 0;
  bit              stall_prev = 0;
  logic [PRIME_EXP-1:0] prev_hash = '0;
  logic [ID_W-1:0] prev_id = '0;
  longint unsigned last_hash = 0;
  logic [ID_W-1:0] last_id = '0;
  longint          last_lat = 0;
  int              out_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_model();
    mc[0] = 258021; mc[1] = 298778; mc[2] = 56536; mc[3] = 214992; mc[4] = 312347;
  endtask

  // Direct polynomial evaluation with 64-bit arithmetic; every term < 2^62.
  function automatic longint unsigned model_hash(input longint unsigned key);
    longint unsigned x;
    longint unsigned h;
    longint unsigned xp;
    x  = key % P;
    h  = 0;
    xp = 1;
    for (int k = 0; k <= DEGREE; k++) begin
      h  = (h + (mc[k] * xp) % P) % P;
      xp = (xp * x) % P;
    end
    return h;
  endfunction

  initial forever begin
    @(posedge axi_aclk);
    cyc++;
  end

  initial forever begin
    @(posedge axi_aclk);
    #1;
    if (rand_ready) m_ready = ($urandom_range(0, 99) < 55);
  end

  // Compare process: sampled mid-cycle, when inputs and outputs are settled.
  initial forever begin
    exp_t e;
    @(negedge axi_aclk);
    if (axi_aresetn) begin
      if (stall_prev) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_hash", 64'(m_hash), 64'(prev_hash));
        check("hold_id", 64'(m_id), 64'(prev_id));
      end
      if (m_valid && m_ready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          check("spurious_output", 64'(m_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("hash", 64'(m_hash), e.hash);
          check("id", 64'(m_id), 64'(e.id));
          check("hash_below_p", 64'(longint'(m_hash) < longint'(P)), 64'd1);
          last_hash = 64'(m_hash);
          last_id   = m_id;
          last_lat  = cyc - e.edge_n;
        end
      end
      if (s_valid && s_ready) begin
        exp_q.push_back('{s_id, model_hash(64'(s_key)), cyc + 1});
      end
      stall_prev = m_valid && !m_ready;
      prev_hash  = m_hash;
      prev_id    = m_id;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic drive_key(input logic [31:0] key, input logic [31:0] id, output bit ok);
    s_valid = 1'b1;
    s_key   = key;
    s_id    = id;
    ok      = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge axi_aclk);
      if (s_ready) ok = 1;
      @(posedge axi_aclk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge axi_aclk);
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic send_check(input string name, input logic [31:0] key, input longint unsigned exp_hash);
    bit ok;
    logic [31:0] id;
    id = $urandom;
    drive_key(key, id, ok);
    check({name, "_accept"}, 64'(ok), 64'd1);
    wait_drain();
    check({name, "_hash"}, last_hash, exp_hash);
    check({name, "_latency"}, 64'(last_lat), 64'd9);
    check({name, "_id"}, 64'(last_id), 64'(id));
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [PRIME_EXP-1:0] data);
    bit in_flight;
    in_flight = (exp_q.size() != 0);
    check("busy_at_cfg", 64'(busy), 64'(in_flight));
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    if (!in_flight && !s_valid && int'(addr) <= DEGREE) mc[addr] = 64'(data) % P;
    @(posedge axi_aclk);
    #1;
    cfg_we = 1'b0;
  endtask

  initial begin
    bit ok;
    int oc0;
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int oc0;
    reset_model();
    repeat (3) @(posedge axi_aclk);
    #1;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_hash", 64'(m_hash), 64'd0);
    check("rst_m_id", 64'(m_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    @(posedge axi_aclk);
    #1;

    send_check("x1", 32'd1, 1140674);
    send_check("x2", 32'd2, 7799209);
    send_check("x0", 32'd0, 258021);
    send_check("xffffffff", 32'hFFFF_FFFF, 1140674);
    send_check("xp", 32'd2147483647, 258021);

    drive_key(32'd5, 32'hA5A5_0005, ok);
    cfg_write(3'd0, 31'd0);
    wait_drain();
    send_check("busy_write_ignored", 32'd1, 1140674);
    cfg_write(3'd0, 31'd0);
    send_check("c0_zero", 32'd1, 882653);
    cfg_write(3'd7, 31'd12345);
    send_check("addr7_ignored", 32'd1, 882653);
    cfg_write(3'd1, 31'h7FFF_FFFF);
    send_check("c1_eq_p", 32'd1, 583875);
    send_check("x2_modified", 32'd2, model_hash(2));

    for (int i = 0; i < 5; i++) drive_key(32'd100 + 32'(i), 32'(i), ok);
    #1;
    axi_aresetn = 1'b0;
    #1;
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    reset_model();
    repeat (2) @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    oc0 = out_count;
    repeat (20) @(posedge axi_aclk);
    #1;
    check("no_stale_output", 64'(out_count - oc0), 64'd0);
    send_check("defaults_restored", 32'd1, 1140674);

    oc0 = out_count;
    rand_ready = 1;
    for (int i = 0; i < 100; i++) begin
      drive_key(32'(i), $urandom, ok);
      check("stream_accept", 64'(ok), 64'd1);
    end
    for (int i = 0; i < 150; i++) begin
      drive_key($urandom, $urandom, ok);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge axi_aclk);
        #1;
      end
    end
    rand_ready = 0;
    m_ready = 1'b1;
    wait_drain();
    check("stream_count", 64'(out_count - oc0), 64'd250);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
